// File: rtl/wb_interconnect_nx.sv
// wb_interconnect_nx: single-master N-slave Wishbone interconnect; M_* master side, S_* packed per-slave side, wb_done_i ends a cycle, err_*_o sticky error flags
module wb_interconnect_nx #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 2,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h1000_0000, 32'h3000_0000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'hFFFF_F000, 32'hF000_0000},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                wb_done_i,
   output logic [DATA_WIDTH-1:0]               M_DAT_I,
   input  logic [ADDR_WIDTH-1:0]               M_ADR_O,
   input  logic [DATA_WIDTH-1:0]               M_DAT_O,
   input  logic                                M_WE_O,
   input  logic [DATA_WIDTH/8-1:0]             M_SEL_O,
   input  logic                                M_STB_O,
   input  logic                                M_CYC_O,
   output logic                                M_ACK_I,
   output logic                                M_ERR_I,
   output logic [NUM_SLAVES*DATA_WIDTH-1:0]    S_DAT_I,
   output logic [NUM_SLAVES*ADDR_WIDTH-1:0]    S_ADR_I,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0]    S_DAT_O,
   output logic [NUM_SLAVES-1:0]               S_WE_I,
   output logic [NUM_SLAVES*DATA_WIDTH/8-1:0]  S_SEL_I,
   output logic [NUM_SLAVES-1:0]               S_STB_I,
   input  logic [NUM_SLAVES-1:0]               S_ACK_O,
   output logic [NUM_SLAVES-1:0]               S_CYC_I,
   output logic                                err_unmapped_o,
   output logic                                err_timeout_o
);
   localparam int SELW = DATA_WIDTH/8;
   localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES+1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES-1 : 0);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, ERR = 2'd2, DRAIN = 2'd3;
   logic [1:0] state;
   logic [SW-1:0] sel, hit_idx;
   logic [CW-1:0] cnt;
   logic hit, act, sel_ack, abort, tmo;
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLAVES-1; i >= 0; i--)
         if ((M_ADR_O & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit = 1'b1;
            hit_idx = SW'(i);
         end
   end
   assign act = state == ACTIVE;
   assign sel_ack = S_ACK_O[sel];
   assign abort = wb_done_i || !M_CYC_O;
   assign tmo = TIMEOUT_CYCLES != 0 && !sel_ack && cnt == TO_LAST;
   always_ff @(posedge clk_i)
      if (rst_i) begin
         state <= IDLE;
         sel <= '0;
         cnt <= '0;
         err_unmapped_o <= 1'b0;
         err_timeout_o <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (M_STB_O && M_CYC_O) begin
                  state <= hit ? ACTIVE : ERR;
                  if (hit) sel <= hit_idx;
                  else err_unmapped_o <= 1'b1;
               end
            ACTIVE:
               if (abort) state <= IDLE;
               else if (tmo) begin
                  state <= ERR;
                  err_timeout_o <= 1'b1;
               end
            ERR: state <= DRAIN;
            default: if (abort) state <= IDLE;
         endcase
         // zero outside ACTIVE doubles as the clear-on-entry; an ACK restarts the window for multi-beat cycles
         cnt <= (act && !sel_ack) ? (cnt == TO_MAX ? cnt : cnt + CW'(1)) : '0;
      end
   always_comb begin
      S_DAT_I = '0;
      S_ADR_I = '0;
      S_WE_I = '0;
      S_SEL_I = '0;
      S_STB_I = '0;
      S_CYC_I = '0;
      if (act) begin
         S_DAT_I[sel*DATA_WIDTH +: DATA_WIDTH] = M_DAT_O;
         S_ADR_I[sel*ADDR_WIDTH +: ADDR_WIDTH] = M_ADR_O;
         S_WE_I[sel] = M_WE_O;
         S_SEL_I[sel*SELW +: SELW] = M_SEL_O;
         S_STB_I[sel] = M_STB_O;
         S_CYC_I[sel] = M_CYC_O;
      end
      M_DAT_I = act ? S_DAT_O[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
      M_ACK_I = act && sel_ack;
      M_ERR_I = state == ERR;
   end
endmodule

// File: tb/tb_wb_interconnect_nx.sv
// tb_wb_interconnect_nx: randomized self-checking bench against a transaction-level decode/timing model
module tb_wb_interconnect_nx;
   localparam int NS = 2;
   localparam int TO = 4;
   localparam logic [63:0] BASE = {32'h1000_0000, 32'h3000_0000};
   localparam logic [63:0] MASK = {32'h1000_0000, 32'hF000_0000};
   logic clk = 0, rst = 1, done = 0;
   logic [31:0] m_adr = 0, m_dat_o = 0, m_dat_i;
   logic m_we = 0, m_stb = 0, m_cyc = 0, m_ack, m_err;
   logic [3:0] m_sel = 0;
   logic [63:0] s_dat_i, s_adr_i, s_dat_o = 0;
   logic [1:0] s_we, s_stb, s_cyc, s_ack = 0;
   logic [7:0] s_sel;
   logic err_unm, err_to;
   logic exp_unm = 0, exp_to = 0;
   int n_chk = 0, n_pass = 0;
   wb_interconnect_nx #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS), .SLV_BASE(BASE),
      .SLV_MASK(MASK), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst), .wb_done_i(done), .M_DAT_I(m_dat_i), .M_ADR_O(m_adr),
      .M_DAT_O(m_dat_o), .M_WE_O(m_we), .M_SEL_O(m_sel), .M_STB_O(m_stb), .M_CYC_O(m_cyc),
      .M_ACK_I(m_ack), .M_ERR_I(m_err), .S_DAT_I(s_dat_i), .S_ADR_I(s_adr_i), .S_DAT_O(s_dat_o),
      .S_WE_I(s_we), .S_SEL_I(s_sel), .S_STB_I(s_stb), .S_ACK_O(s_ack), .S_CYC_I(s_cyc),
      .err_unmapped_o(err_unm), .err_timeout_o(err_to));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog got=hang exp=finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask
   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
      return -1;
   endfunction
   task automatic idle_check(input string tag);
      chk({tag, "_ctl"}, {m_ack, m_err, s_stb, s_cyc, s_we, s_sel}, 0);
      chk({tag, "_bus"}, s_adr_i | s_dat_i | 64'(m_dat_i), 0);
      chk({tag, "_flags"}, {err_unm, err_to}, {exp_unm, exp_to});
   endtask
   task automatic act_check(input int k, input bit ack);
      chk("act_stb", s_stb, 2'(m_stb) << k);
      chk("act_cyc", s_cyc, 2'(m_cyc) << k);
      chk("act_we", s_we, 2'(m_we) << k);
      chk("act_sel", s_sel, 8'(m_sel) << (4*k));
      chk("act_adr", s_adr_i, 64'(m_adr) << (32*k));
      chk("act_wdat", s_dat_i, 64'(m_dat_o) << (32*k));
      chk("act_ack", m_ack, ack);
      chk("act_rdat", m_dat_i, s_dat_o[32*k +: 32]);
      chk("act_err", m_err, 0);
   endtask
   task automatic err_tail();
      s_ack = 2'($urandom);
      @(negedge clk);
      chk("err_pulse", m_err, 1);
      chk("err_nostb", {s_stb, s_cyc}, 0);
      chk("err_ack", m_ack, 0);
      chk("err_flags", {err_unm, err_to}, {exp_unm, exp_to});
      @(posedge clk); #1;
      @(negedge clk);
      chk("drain_err", m_err, 0);
      chk("drain_stb", {s_stb, s_cyc, m_ack}, 0);
      done = 1; m_cyc = 0; m_stb = 0;
      @(posedge clk); #1;
      done = 0;
   endtask
   // ack_at/abort_at: ACTIVE-cycle index of the slave ACK / master abort, -1 for none
   task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] sl,
                      input logic [63:0] sd, input int ack_at, input bit dwa, input int abort_at, input bit abort_rst);
      int k;
      bit fin;
      k = decode(a);
      m_adr = a; m_we = w; m_dat_o = d; m_sel = sl; s_dat_o = sd; m_stb = 1; m_cyc = 1; s_ack = 0;
      @(negedge clk);
      chk("dec_stb", {s_stb, s_cyc}, 0);
      chk("dec_ack", {m_ack, m_err}, 0);
      @(posedge clk); #1;
      if (k < 0) begin
         exp_unm = 1;
         err_tail();
      end else begin
         fin = 0;
         for (int j = 0; !fin; j++) begin
            s_ack = (2'($urandom) & ~(2'b01 << k)) | (2'(j == ack_at) << k);
            if (j == abort_at) begin
               if (abort_rst) rst = 1;
               else begin m_cyc = 0; m_stb = 0; end
            end
            done = (j == ack_at) && dwa;
            @(negedge clk);
            act_check(k, j == ack_at);
            @(posedge clk); #1;
            if (j == abort_at) begin
               fin = 1;
               if (abort_rst) begin rst = 0; exp_unm = 0; exp_to = 0; end
            end else if (j == ack_at) begin
               fin = 1;
               if (!dwa) begin
                  done = 1; m_stb = 0;
                  s_ack = 2'($urandom) & ~(2'b01 << k);
                  @(negedge clk);
                  act_check(k, 0);
                  @(posedge clk); #1;
               end
            end else if (j == TO-1) begin
               fin = 1;
               exp_to = 1;
               err_tail();
            end
         end
      end
      done = 0; m_stb = 0; m_cyc = 0; s_ack = 0;
      @(negedge clk);
      idle_check("end");
      @(posedge clk); #1;
   endtask
   initial begin
      logic [31:0] a;
      int r, ack_at, abort_at;
      repeat (3) @(posedge clk);
      @(negedge clk);
      idle_check("reset");
      @(posedge clk); #1;
      rst = 0;
      txn(32'h3000_0040, 0, 32'h0, 4'hF, {32'h1111_2222, 32'hDEAD_BEEF}, 2, 1, -1, 0);
      txn(32'h1000_0004, 1, 32'h55, 4'b0001, {32'hCAFE_0001, 32'h0}, 1, 0, -1, 0);
      txn(32'h2000_0000, 0, 32'h0, 4'hF, 64'h0, -1, 1, -1, 0);
      txn(32'h3000_0100, 0, 32'h0, 4'hF, 64'h0123_4567_89AB_CDEF, -1, 1, -1, 0);
      txn(32'h3000_0000, 1, 32'hA5A5_5A5A, 4'hC, 64'hFFFF_0000_0000_FFFF, 0, 1, -1, 0);
      txn(32'h3000_0008, 0, 32'h0, 4'hF, 64'h1, -1, 1, 1, 0);
      txn(32'h1000_0010, 1, 32'h77, 4'h3, 64'h2, -1, 1, 3, 0);
      txn(32'h3000_0020, 0, 32'h0, 4'hF, 64'h3, -1, 1, 2, 1);
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: a = {4'h3, 28'($urandom)};
            1: a = {20'h10000, 12'($urandom)};
            2: a = {4'h2, 28'($urandom)};
            default: a = $urandom;
         endcase
         r = $urandom_range(0, 4);
         ack_at = r == 4 ? -1 : r;
         abort_at = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 3)) : -1;
         txn(a, 1'($urandom), $urandom, 4'($urandom), {$urandom, $urandom}, ack_at, 1'($urandom),
             abort_at, 1'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
